// File: rtl/dccm_resp.sv
// DCCM responder: word-organised SRAM with 1-cycle read latency, post-reset array
// clear, write-first forwarding and a sticky record of the first bad access.
module dccm_resp #(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dccm_wr_en,
    input  logic [31:0] dccm_wr_addr,
    input  logic [31:0] dccm_wr_data,
    input  logic        dccm_rd_en,
    input  logic [31:0] dccm_rd_addr,
    output logic [31:0] dccm_rd_data,
    output logic        dccm_rd_valid,
    output logic        init_busy,
    input  logic        err_clr,
    output logic        err_flag,
    output logic [31:0] err_addr
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t         state;
    logic [AW-1:0]  clr_cnt;
    logic [31:0]    mem [DEPTH];

    logic [31:0]    wr_off, rd_off;
    logic           wr_good, rd_good;
    logic [AW-1:0]  wr_idx, rd_idx;
    logic           wr_bad, rd_bad;
    logic           fwd;
    logic           mem_we;
    logic [AW-1:0]  mem_idx;
    logic [31:0]    mem_wdata;

    // Offsets wrap modulo 2^32, so addresses below BASE land far out of range.
    always_comb begin
        wr_off    = dccm_wr_addr - BASE;
        rd_off    = dccm_rd_addr - BASE;
        wr_good   = (wr_off < SPAN) && (dccm_wr_addr[1:0] == 2'b00);
        rd_good   = (rd_off < SPAN) && (dccm_rd_addr[1:0] == 2'b00);
        wr_idx    = wr_off[AW+1:2];
        rd_idx    = rd_off[AW+1:2];
        wr_bad    = (state == RUN) && dccm_wr_en && !wr_good;
        rd_bad    = (state == RUN) && dccm_rd_en && !rd_good;
        fwd       = dccm_wr_en && wr_good && (wr_idx == rd_idx);
        mem_we    = rst_n && ((state == CLEAR) || (dccm_wr_en && wr_good));
        mem_idx   = (state == CLEAR) ? clr_cnt : wr_idx;
        mem_wdata = (state == CLEAR) ? 32'h0 : dccm_wr_data;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_idx] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= CLEAR;
            clr_cnt       <= '0;
            init_busy     <= 1'b1;
            dccm_rd_data  <= 32'h0;
            dccm_rd_valid <= 1'b0;
            err_flag      <= 1'b0;
            err_addr      <= 32'h0;
        end else begin
            case (state)
                CLEAR: begin
                    dccm_rd_valid <= 1'b0;
                    clr_cnt       <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    dccm_rd_valid <= dccm_rd_en;
                    if (dccm_rd_en) begin
                        if (!rd_good)
                            dccm_rd_data <= 32'h0;
                        else if (fwd)
                            dccm_rd_data <= dccm_wr_data;
                        else
                            dccm_rd_data <= mem[rd_idx];
                    end
                end
                default: begin
                    state     <= CLEAR;
                    init_busy <= 1'b1;
                end
            endcase

            // Clear beats a simultaneous new error; the write address wins a tie.
            if (err_clr) begin
                err_flag <= 1'b0;
                err_addr <= 32'h0;
            end else if (!err_flag) begin
                if (wr_bad) begin
                    err_flag <= 1'b1;
                    err_addr <= dccm_wr_addr;
                end else if (rd_bad) begin
                    err_flag <= 1'b1;
                    err_addr <= dccm_rd_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_dccm_resp.sv
// Directed bench for dccm_resp (DEPTH=16, BASE=0) with hand-computed expectations.
module tb_dccm_resp;

    logic        clk;
    logic        rst_n;
    logic        dccm_wr_en;
    logic [31:0] dccm_wr_addr;
    logic [31:0] dccm_wr_data;
    logic        dccm_rd_en;
    logic [31:0] dccm_rd_addr;
    logic [31:0] dccm_rd_data;
    logic        dccm_rd_valid;
    logic        init_busy;
    logic        err_clr;
    logic        err_flag;
    logic [31:0] err_addr;

    int vectors;
    int miscompares;
    int busy_cycles;
    logic saw_valid;

    dccm_resp #(.DEPTH(16), .BASE(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dccm_wr_en    (dccm_wr_en),
        .dccm_wr_addr  (dccm_wr_addr),
        .dccm_wr_data  (dccm_wr_data),
        .dccm_rd_en    (dccm_rd_en),
        .dccm_rd_addr  (dccm_rd_addr),
        .dccm_rd_data  (dccm_rd_data),
        .dccm_rd_valid (dccm_rd_valid),
        .init_busy     (init_busy),
        .err_clr       (err_clr),
        .err_flag      (err_flag),
        .err_addr      (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic wr, input logic [31:0] waddr, input logic [31:0] wdata,
                                  input logic rd, input logic [31:0] raddr, input logic clr);
        dccm_wr_en   = wr;
        dccm_wr_addr = waddr;
        dccm_wr_data = wdata;
        dccm_rd_en   = rd;
        dccm_rd_addr = raddr;
        err_clr      = clr;
    endtask

    task automatic count_clear();
        busy_cycles = 0;
        saw_valid   = 1'b0;
        while (init_busy === 1'b1 && busy_cycles < 100) begin
            tick();
            busy_cycles++;
            if (dccm_rd_valid !== 1'b0) saw_valid = 1'b1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_output("reset_rd_data", dccm_rd_data, 32'h0);
        check_output("reset_rd_valid", 32'(dccm_rd_valid), 32'h0);
        check_output("reset_err_flag", 32'(err_flag), 32'h0);
        check_output("reset_err_addr", err_addr, 32'h0);
        check_output("reset_init_busy", 32'(init_busy), 32'h1);

        // Release reset with a read held during the clear
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 1, 32'h0C, 0);
        count_clear();
        check_output("clear_cycles", 32'(busy_cycles), 32'd16);
        check_output("clear_no_valid", 32'(saw_valid), 32'h0);
        check_output("clear_rd_data_zero", dccm_rd_data, 32'h0);
        tick();
        check_output("first_read_valid", 32'(dccm_rd_valid), 32'h1);
        check_output("first_read_data", dccm_rd_data, 32'h0);
        check_output("first_read_no_err", 32'(err_flag), 32'h0);

        // Write then read
        apply_stimulus(1, 32'h08, 32'hDEADBEEF, 0, 0, 0);
        tick();
        check_output("idle_valid_low", 32'(dccm_rd_valid), 32'h0);
        apply_stimulus(0, 0, 0, 1, 32'h08, 0);
        tick();
        check_output("wr_rd_valid", 32'(dccm_rd_valid), 32'h1);
        check_output("wr_rd_data", dccm_rd_data, 32'hDEADBEEF);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();
        check_output("hold_valid_low", 32'(dccm_rd_valid), 32'h0);
        check_output("hold_data", dccm_rd_data, 32'hDEADBEEF);

        // Same-cycle write/read forwarding
        apply_stimulus(1, 32'h10, 32'h12345678, 1, 32'h10, 0);
        tick();
        check_output("fwd_data", dccm_rd_data, 32'h12345678);
        apply_stimulus(0, 0, 0, 1, 32'h10, 0);
        tick();
        check_output("fwd_reread", dccm_rd_data, 32'h12345678);

        // Bad accesses
        apply_stimulus(1, 32'h40, 32'hCAFEF00D, 0, 0, 0);
        tick();
        check_output("oob_wr_flag", 32'(err_flag), 32'h1);
        check_output("oob_wr_addr", err_addr, 32'h40);
        apply_stimulus(0, 0, 0, 1, 32'h05, 0);
        tick();
        check_output("misal_rd_valid", 32'(dccm_rd_valid), 32'h1);
        check_output("misal_rd_data", dccm_rd_data, 32'h0);
        check_output("sticky_err_addr", err_addr, 32'h40);
        apply_stimulus(0, 0, 0, 1, 32'h00, 0);
        tick();
        check_output("oob_wr_dropped", dccm_rd_data, 32'h0);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        tick();
        check_output("clr_flag", 32'(err_flag), 32'h0);
        check_output("clr_addr", err_addr, 32'h0);
        apply_stimulus(1, 32'h44, 32'h1, 0, 0, 1);
        tick();
        check_output("clr_wins_flag", 32'(err_flag), 32'h0);
        check_output("clr_wins_addr", err_addr, 32'h0);
        apply_stimulus(1, 32'h80, 32'h1, 1, 32'h03, 0);
        tick();
        check_output("both_bad_flag", 32'(err_flag), 32'h1);
        check_output("both_bad_wr_addr", err_addr, 32'h80);
        apply_stimulus(1, 32'h02, 32'hBAD0BAD0, 0, 0, 1);
        tick();
        apply_stimulus(0, 0, 0, 1, 32'h00, 0);
        tick();
        check_output("misal_wr_dropped", dccm_rd_data, 32'h0);

        // Pipelined reads of four preloaded words
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 32'(i * 4), 32'(i + 1), 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 0, 1, 32'(i * 4), 0);
            tick();
            check_output($sformatf("pipe_valid_%0d", i), 32'(dccm_rd_valid), 32'h1);
            check_output($sformatf("pipe_data_%0d", i), dccm_rd_data, 32'(i + 1));
        end
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();
        check_output("pipe_end_valid", 32'(dccm_rd_valid), 32'h0);

        // Reset mid-run
        apply_stimulus(1, 32'h04, 32'hA5A5A5A5, 1, 32'h41, 0);
        tick();
        check_output("pre_reset_err", 32'(err_flag), 32'h1);
        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();
        check_output("rerst_busy", 32'(init_busy), 32'h1);
        check_output("rerst_err_flag", 32'(err_flag), 32'h0);
        check_output("rerst_rd_data", dccm_rd_data, 32'h0);
        rst_n = 1'b1;
        count_clear();
        check_output("reclear_cycles", 32'(busy_cycles), 32'd16);
        apply_stimulus(0, 0, 0, 1, 32'h04, 0);
        tick();
        check_output("reclear_valid", 32'(dccm_rd_valid), 32'h1);
        check_output("reclear_data", dccm_rd_data, 32'h0);
        check_output("reclear_err", 32'(err_flag), 32'h0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dccm_resp.md
Name: dccm_resp

Overview:
- Data-side memory responder that terminates the core's DCCM port, the target end of the core's load/store initiator.
- Holds a word-organised SRAM array and serves one read and one write per cycle, with a fixed 1-cycle read latency.
- Clears the whole array after reset.
- Flags out-of-range or misaligned accesses through a sticky error record.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, minimum 4.
- BASE, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- dccm_wr_en  in  1  write request this cycle.
- dccm_wr_addr  in  32  write byte address.
- dccm_wr_data  in  32  write data.
- dccm_rd_en  in  1  read request this cycle.
- dccm_rd_addr  in  32  read byte address.
- dccm_rd_data  out  32  read data, valid the cycle after an accepted read.
- dccm_rd_valid  out  1  high exactly one cycle after an accepted read.
- init_busy  out  1  array clear in progress; requests ignored.
- err_clr  in  1  clears err_flag and err_addr.
- err_flag  out  1  sticky: a bad access occurred.
- err_addr  out  32  byte address of the first bad access since the last clear.

Behaviour:
- Reset (rst_n=0 sampled at clk edge):
  - Outputs: dccm_rd_data=0, dccm_rd_valid=0, err_flag=0, err_addr=0, init_busy=1.
  - Clear counter returns to 0 and FSM returns to CLEAR, including when reset is asserted mid-clear or mid-transfer.
  - Array contents are not reset directly; they are overwritten by CLEAR.
- FSM states:
  - CLEAR: writes 0 to word clr_cnt each cycle; clr_cnt increments. When clr_cnt==DEPTH-1 is written, go to RUN.
  - CLEAR lasts exactly DEPTH cycles after the first cycle with rst_n=1.
  - init_busy=1 in CLEAR, 0 in RUN.
  - RUN: serve requests. Remain in RUN until reset.
- During CLEAR:
  - dccm_wr_en and dccm_rd_en are ignored: no array write, no rd_valid, no error logged.
  - dccm_rd_data holds 0.
- Address check, applied independently to each port:
  - off = addr - BASE, 32-bit unsigned wrap.
  - Good iff off < DEPTH*4 and addr[1:0]==0.
  - Word index = off[log2(DEPTH)+1:2].
- Write (RUN, wr_en=1):
  - Good address: array[idx] <= wr_data at the edge.
  - Bad address: write dropped, error logged.
- Read (RUN, rd_en=1):
  - Next cycle dccm_rd_valid=1.
  - dccm_rd_data = array[idx] for a good address; 0 for a bad address, with error logged.
- rd_en=0:
  - dccm_rd_valid=0 next cycle.
  - dccm_rd_data holds its last value.
- Same-cycle read and write to the same good word: read returns the new wr_data (write-first forwarding).
- Back-to-back reads are fully pipelined, one result per cycle.
- Error logging:
  - If err_flag=0 and a bad access occurs, err_flag<=1 and err_addr<=the bad address.
  - If read and write are both bad in the same cycle, the write address is recorded.
  - While err_flag=1, further bad accesses do not change err_addr.
- err_clr:
  - err_clr=1 clears err_flag and err_addr to 0 next cycle.
  - err_clr=1 together with a new bad access: clear wins; the new error is not logged.
- No back-pressure: every RUN request is accepted in the cycle presented.

Test Plan:
- CLEAR timing: DEPTH=16, release rst_n → init_busy high for exactly 16 cycles. A rd_en during CLEAR gives no rd_valid. The first read in RUN of 0x0C returns 0.
- Write then read: write 0xDEADBEEF to 0x08, read 0x08 next cycle → rd_valid=1 and rd_data=0xDEADBEEF one cycle after the read.
- Forwarding: same cycle, write 0x12345678 to 0x10 and read 0x10 → rd_data=0x12345678 next cycle. Next read of 0x10 returns the same value.
- Bad accesses, DEPTH=16, BASE=0:
  - Write to 0x40 → dropped; err_flag=1, err_addr=0x40.
  - Then misaligned read 0x05 → rd_data=0, err_addr stays 0x40.
  - err_clr → both 0.
- Pipelined reads: preload 0x00..0x0C with 1,2,3,4; read all four on consecutive cycles → rd_valid high 4 cycles, data 1,2,3,4 in order.
- Reset mid-run: write 0xA5A5A5A5 to 0x04; assert rst_n=0 for 1 cycle, then release → init_busy=1 for DEPTH cycles, err_flag=0. Read 0x04 afterwards → 0.
